fpu_result_capture: RTL and testbench
=====================================

# fpu_result_capture

Captures each completed FPU operation (arithmetic result or compare outcome, plus its FPCSR exception flags) from the mor1kx FPU output port into a small FIFO. It presents the results to a downstream consumer, such as a writeback stage or a scoreboard, over a valid/ready interface. It sits directly downstream of the FPU. It converts level-held FPU valid signals into exactly one entry per operation and accumulates sticky exception flags across operations.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, $clog2(DEPTH+1): width of count_o.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  FPU pipeline flush; suppresses capture in that cycle.
- result_i  in  32  FPU arithmetic result (fpuOut).
- valid_arith_i  in  1  FPU arithmetic-result valid; level, may stay high many cycles.
- cmp_flag_i  in  1  FPU compare outcome.
- valid_cmp_i  in  1  FPU compare-result valid; level.
- fpcsr_i  in  12  FPU FPCSR; flags are bits [11:3].
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accepts head.
- out_data_o  out  32  head result.
- out_cmp_o  out  1  head compare outcome.
- out_is_cmp_o  out  1  head came from a compare-only operation.
- out_flags_o  out  9  head fpcsr_i[11:3].
- sticky_flags_o  out  9  OR of flags of all captured operations since reset or clear.
- sticky_clr_i  in  1  clear sticky flags.
- overflow_o  out  1  sticky; set when a capture hits a full FIFO; cleared only by rst.
- count_o  out  CNT_W  current occupancy.

## Operation
- The block registers v_prev = valid_arith_i | valid_cmp_i every cycle.
- A capture event occurs when (valid_arith_i | valid_cmp_i) & !v_prev & !flush_i.
- Entry contents: data=result_i, cmp=cmp_flag_i, is_cmp=valid_cmp_i & !valid_arith_i, flags=fpcsr_i[11:3].
- If valid_arith_i and valid_cmp_i rise together, the block writes one entry with is_cmp=0.
- If flush_i is high in the rising cycle, the operation is lost. v_prev still updates, so the same held valid does not capture later.
- Pop occurs when out_valid_o & out_ready_i. The head advances and count_o decrements.
- Push and pop in the same cycle:
  - Not full: both take effect and count_o is unchanged.
  - Full: the pop frees a slot, the push is accepted, and overflow_o is not set.
  - Empty: the push is accepted. There is no bypass; out_valid_o rises the next cycle.
- A capture while full with no pop: the entry is dropped and overflow_o is set. Its flags still OR into sticky_flags_o.
- Sticky update: sticky <= (sticky_clr_i ? 0 : sticky) | (capture ? flags : 0). When clear and capture occur in the same cycle, the result holds only the new entry's flags.
- FIFO pointers are log2(DEPTH) bits with natural wrap. Full/empty comes from count, which is 0..DEPTH.
- flush_i does not touch FIFO contents, sticky flags or overflow_o.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_cmp_o=0, out_is_cmp_o=0, out_flags_o=0, sticky_flags_o=0, overflow_o=0, count_o=0. v_prev=0 and pointers are 0.
- Reset mid-operation empties the FIFO immediately (asynchronous).
- If a valid is still held high when rst deasserts, it is captured on the first clock edge after release, because v_prev=0.
- Capture latency: the edge of cycle N (the rising-valid cycle) writes the entry. out_valid_o and count_o reflect it after that edge, in cycle N+1.
- Head outputs are register/array reads of the head slot. When out_valid_o=0 they hold their last value and are don't-care.
- out_valid_o depends only on state and has no combinational path from out_ready_i.
- Throughput: one capture and one pop per cycle.

## Configuration
- Macro FPU_RESULT_CAPTURE_STICKY_EN.
- Defined: sticky_flags_o and sticky_clr_i behave as described above.
- Undefined: sticky_flags_o is tied to 0, sticky_clr_i is ignored and no sticky register is built.
- The ports exist in both cases. FIFO entries always carry flags.

## Test plan
- Reset, then hold valid_arith_i=1 for 5 cycles with result_i=32'h3F800000 and fpcsr_i[11:3]=9'h020. Expect exactly one entry, count_o=1, out_data_o=32'h3F800000, out_flags_o=9'h020, sticky_flags_o=9'h020.
- Raise valid_cmp_i with cmp_flag_i=1, valid_arith_i=0, then pop with out_ready_i=1. Expect out_is_cmp_o=1, out_cmp_o=1, and count_o returning to 0 the cycle after the pop.
- Raise valid_arith_i in the same cycle as flush_i=1 and hold valid 3 cycles. Expect no entry, count_o=0; the next low→high valid is captured.
- DEPTH=4 with out_ready_i=0: 5 operations with results 1..5. Expect count_o=4, overflow_o=1, and pops return 1,2,3,4. Sticky flags include flags of operation 5.
- Full FIFO with a capture and pop in the same cycle. Expect count_o stays 4, overflow_o stays 0, and the new entry is last out.
- With FPU_RESULT_CAPTURE_STICKY_EN defined, assert sticky_clr_i together with a capture carrying flags 9'h001. Expect sticky_flags_o=9'h001. Without the macro, expect sticky_flags_o=0 throughout.

Source files
------------

// File: rtl/fpu_result_capture.sv
// Captures each completed FPU operation (result/compare + FPCSR flags) into a FIFO
// with a valid/ready head. Optional sticky flag accumulation: FPU_RESULT_CAPTURE_STICKY_EN.
module fpu_result_capture #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [31:0]      result_i,
    input  logic             valid_arith_i,
    input  logic             cmp_flag_i,
    input  logic             valid_cmp_i,
    input  logic [11:0]      fpcsr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_cmp_o,
    output logic             out_is_cmp_o,
    output logic [8:0]       out_flags_o,
    output logic [8:0]       sticky_flags_o,
    input  logic             sticky_clr_i,
    output logic             overflow_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic        cmp;
        logic        is_cmp;
        logic [8:0]  flags;
    } entry_t;

    logic             v_prev_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;
    entry_t           mem_r [DEPTH];

    logic             v_any_s;
    logic             capture_s;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic [CNT_W-1:0] count_nxt_s;
    entry_t           entry_s;
    entry_t           head_s;
    logic             unused_s;

    assign v_any_s   = valid_arith_i | valid_cmp_i;
    assign capture_s = v_any_s & ~v_prev_r & ~flush_i;
    assign full_s    = (count_r == CNT_W'(DEPTH));
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign pop_s     = ~empty_s & out_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_s    = capture_s & (~full_s | pop_s);
    assign drop_s    = capture_s & full_s & ~pop_s;
    assign unused_s  = ^{fpcsr_i[2:0], sticky_clr_i};

    // Build the entry for the current operation.
    always_comb begin
        entry_s        = '0;
        entry_s.data   = result_i;
        entry_s.cmp    = cmp_flag_i;
        entry_s.is_cmp = valid_cmp_i & ~valid_arith_i;
        entry_s.flags  = fpcsr_i[11:3];
    end

    // Next occupancy from push/pop.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Edge detect register, pointers, occupancy and overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_prev_r   <= 1'b0;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            v_prev_r <= v_any_s;
            count_r  <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // FIFO storage; cleared on reset so head outputs read zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
            end
        end
    end

`ifdef FPU_RESULT_CAPTURE_STICKY_EN
    logic [8:0] sticky_r;
    logic [8:0] sticky_nxt_s;

    // Clear applies first so a simultaneous capture keeps only its own flags.
    always_comb begin
        sticky_nxt_s = sticky_clr_i ? 9'h000 : sticky_r;
        if (capture_s) begin
            sticky_nxt_s = sticky_nxt_s | entry_s.flags;
        end else begin
            sticky_nxt_s = sticky_nxt_s;
        end
    end

    // Sticky exception flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r <= 9'h000;
        end else begin
            sticky_r <= sticky_nxt_s;
        end
    end

    assign sticky_flags_o = sticky_r;
`else
    assign sticky_flags_o = 9'h000;
`endif

    assign head_s       = mem_r[rd_ptr_r];
    assign out_valid_o  = ~empty_s;
    assign out_data_o   = head_s.data;
    assign out_cmp_o    = head_s.cmp;
    assign out_is_cmp_o = head_s.is_cmp;
    assign out_flags_o  = head_s.flags;
    assign overflow_o   = overflow_r;
    assign count_o      = count_r;

endmodule

// File: tb/tb_fpu_result_capture.sv
// Scoreboard bench for fpu_result_capture: stimulus pushes expected entries,
// a negedge monitor pops and compares whenever the head is accepted.
module tb_fpu_result_capture;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic [31:0]      result_i;
    logic             valid_arith_i;
    logic             cmp_flag_i;
    logic             valid_cmp_i;
    logic [11:0]      fpcsr_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      out_data_o;
    logic             out_cmp_o;
    logic             out_is_cmp_o;
    logic [8:0]       out_flags_o;
    logic [8:0]       sticky_flags_o;
    logic             sticky_clr_i;
    logic             overflow_o;
    logic [CNT_W-1:0] count_o;

    logic [42:0] exp_q [$];
    logic [8:0]  exp_sticky;
    int          n_checks = 0;
    int          n_pass   = 0;

    fpu_result_capture #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .result_i(result_i),
        .valid_arith_i(valid_arith_i), .cmp_flag_i(cmp_flag_i),
        .valid_cmp_i(valid_cmp_i), .fpcsr_i(fpcsr_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_cmp_o(out_cmp_o),
        .out_is_cmp_o(out_is_cmp_o), .out_flags_o(out_flags_o),
        .sticky_flags_o(sticky_flags_o), .sticky_clr_i(sticky_clr_i),
        .overflow_o(overflow_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Monitor: an accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        logic [42:0] e;
        if (!rst && out_valid_o && out_ready_i) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected: got %h, expected no entry",
                         {out_data_o, out_cmp_o, out_is_cmp_o, out_flags_o});
            end else begin
                e = exp_q.pop_front();
                if ({out_data_o, out_cmp_o, out_is_cmp_o, out_flags_o} === e) begin
                    n_pass++;
                end else begin
                    $display("FAIL pop_entry: got %h, expected %h",
                             {out_data_o, out_cmp_o, out_is_cmp_o, out_flags_o}, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_sticky(input string name);
`ifdef FPU_RESULT_CAPTURE_STICKY_EN
        check(name, 32'(sticky_flags_o), 32'(exp_sticky));
`else
        check(name, 32'(sticky_flags_o), 32'h0000_0000);
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_sticky = 9'h000;
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    // One operation: valid high for one cycle, then low for one cycle.
    task automatic op(input logic [31:0] r, input logic [8:0] f, input logic a,
                      input logic c, input logic cf, input logic stored);
        result_i = r; fpcsr_i = {f, 3'b000};
        valid_arith_i = a; valid_cmp_i = c; cmp_flag_i = cf;
        if (stored) exp_q.push_back({r, cf, c & ~a, f});
        exp_sticky = (sticky_clr_i ? 9'h000 : exp_sticky) | f;
        cyc();
        valid_arith_i = 1'b0; valid_cmp_i = 1'b0; sticky_clr_i = 1'b0;
        cyc();
    endtask

    task automatic drain(input string name);
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
        cyc();
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'h0000_0000);
        check({name, "_count_zero"}, 32'(count_o), 32'h0000_0000);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; result_i = 32'h0; valid_arith_i = 1'b0;
        cmp_flag_i = 1'b0; valid_cmp_i = 1'b0; fpcsr_i = 12'h000;
        out_ready_i = 1'b0; sticky_clr_i = 1'b0; exp_sticky = 9'h000;
        do_reset();

        check("rst_valid", 32'(out_valid_o), 32'h0);
        check("rst_count", 32'(count_o), 32'h0);
        check("rst_data", out_data_o, 32'h0);
        check("rst_flags", 32'(out_flags_o), 32'h0);
        check("rst_overflow", 32'(overflow_o), 32'h0);
        check_sticky("rst_sticky");

        // Level-held valid for 5 cycles yields one entry.
        result_i = 32'h3F80_0000; fpcsr_i = {9'h020, 3'b000}; valid_arith_i = 1'b1;
        exp_q.push_back({32'h3F80_0000, 1'b0, 1'b0, 9'h020});
        exp_sticky = 9'h020;
        repeat (5) cyc();
        valid_arith_i = 1'b0;
        cyc();
        check("held_count", 32'(count_o), 32'h1);
        check("held_data", out_data_o, 32'h3F80_0000);
        check("held_flags", 32'(out_flags_o), 32'h20);
        check_sticky("held_sticky");
        out_ready_i = 1'b1;
        cyc();
        check("held_pop_count", 32'(count_o), 32'h0);
        out_ready_i = 1'b0;

        // Compare-only operation.
        op(32'h0, 9'h010, 1'b0, 1'b1, 1'b1, 1'b1);
        check("cmp_count", 32'(count_o), 32'h1);
        check("cmp_is_cmp", 32'(out_is_cmp_o), 32'h1);
        check("cmp_flag", 32'(out_cmp_o), 32'h1);
        out_ready_i = 1'b1;
        cyc();
        check("cmp_pop_count", 32'(count_o), 32'h0);

        // Flush on the rising cycle loses the op even though valid stays high.
        flush_i = 1'b1; valid_arith_i = 1'b1; result_i = 32'hDEAD_BEEF;
        fpcsr_i = {9'h1FF, 3'b000};
        cyc();
        flush_i = 1'b0;
        cyc(); cyc();
        valid_arith_i = 1'b0;
        cyc();
        check("flush_count", 32'(count_o), 32'h0);
        check_sticky("flush_sticky");
        out_ready_i = 1'b0;
        op(32'h4000_0000, 9'h004, 1'b1, 1'b0, 1'b0, 1'b1);
        check("post_flush_count", 32'(count_o), 32'h1);
        // Arith and compare rising together: one entry, not compare-only.
        op(32'h4040_0000, 9'h008, 1'b1, 1'b1, 1'b1, 1'b1);
        check("both_count", 32'(count_o), 32'h2);
        drain("after_flush");

        // Full FIFO with capture and pop in the same cycle.
        out_ready_i = 1'b0;
        for (int i = 11; i <= 14; i++) op(32'(i), 9'h000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("fill_count", 32'(count_o), 32'h4);
        result_i = 32'd15; fpcsr_i = {9'h040, 3'b000}; valid_arith_i = 1'b1;
        out_ready_i = 1'b1;
        exp_q.push_back({32'd15, 1'b0, 1'b0, 9'h040});
        exp_sticky = exp_sticky | 9'h040;
        cyc();
        out_ready_i = 1'b0; valid_arith_i = 1'b0;
        check("full_pushpop_count", 32'(count_o), 32'h4);
        check("full_pushpop_overflow", 32'(overflow_o), 32'h0);
        cyc();
        drain("full_pushpop");

        // Overflow: five ops into a four-deep FIFO.
        do_reset();
        out_ready_i = 1'b0;
        op(32'd1, 9'h001, 1'b1, 1'b0, 1'b0, 1'b1);
        op(32'd2, 9'h002, 1'b1, 1'b0, 1'b0, 1'b1);
        op(32'd3, 9'h004, 1'b1, 1'b0, 1'b0, 1'b1);
        op(32'd4, 9'h008, 1'b1, 1'b0, 1'b0, 1'b1);
        op(32'd5, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        check("ovf_count", 32'(count_o), 32'h4);
        check("ovf_flag", 32'(overflow_o), 32'h1);
        check_sticky("ovf_sticky");
        drain("ovf");
        check("ovf_persists", 32'(overflow_o), 32'h1);

        // Sticky clear together with a capture keeps only the new flags.
        sticky_clr_i = 1'b1;
        op(32'h1234_5678, 9'h001, 1'b1, 1'b0, 1'b0, 1'b1);
        check_sticky("clr_capture_sticky");
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
